uart_tx_arbiter: RTL and testbench

//  Shares the single UART_TX transmitter between two byte sources: req0 is the CPU console path and req1 is the debug/OCD reply path.

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter_rr.sv | 20 ++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-source UART transmit arbiter.
package uart_tx_arbiter_pkg;

    localparam int DEF_ACK_TIMEOUT = 1000;
    localparam int DEF_LOCK_IDLE   = 50000;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_OCD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_ACT  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_HOLD      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes and UART_TX side-band bundled for the arbiter.
interface uart_tx_arbiter_if;

    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       start_TX;
    logic [7:0] tx_data;
    logic       tx_active;
    logic       grant;
    logic       busy;
    logic       tx_err;

    modport master (
        output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, tx_active,
        input  req0_ready, req1_ready, start_TX, tx_data, grant, busy, tx_err
    );

    modport slave (
        input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, tx_active,
        output req0_ready, req1_ready, start_TX, tx_data, grant, busy, tx_err
    );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Two-way round-robin selector; a held lock pins the selection to its owner.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       rr_last,
    input  logic       lock_en,
    input  logic       lock_id,
    output logic       sel
);

    always_comb begin
        sel = ~rr_last;
        if (lock_en)
            sel = lock_id;
        else if (valid == 2'b01)
            sel = 1'b0;
        else if (valid == 2'b10)
            sel = 1'b1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX between the CPU console and OCD reply byte streams.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter logic LOCK_PACKET  = 1'b1,
    parameter int   TIMEOUT_BITS = 16,
    parameter int   ACK_TIMEOUT  = DEF_ACK_TIMEOUT,
    parameter int   LOCK_IDLE    = DEF_LOCK_IDLE
) (
    input logic              clk,
    input logic              reset,
    input logic              sync_reset,
    uart_tx_arbiter_if.slave bus
);

    localparam logic [TIMEOUT_BITS-1:0] ACK_LIMIT  = TIMEOUT_BITS'(ACK_TIMEOUT - 1);
    localparam logic [TIMEOUT_BITS-1:0] LOCK_LIMIT = TIMEOUT_BITS'(LOCK_IDLE - 1);
    localparam logic [TIMEOUT_BITS-1:0] CNT_MAX    = '1;
    localparam logic [TIMEOUT_BITS-1:0] CNT_ONE    = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};

    arb_state_t              state, state_next;
    logic [TIMEOUT_BITS-1:0] cnt, cnt_inc;
    logic [7:0]              data_q, sel_data;
    logic                    last_q, sel_last;
    logic                    grant_q, rr_last, tx_err_q;
    logic                    sel, accept, ready0, ready1, start, owner_valid;

    rr_arbiter_2 u_rr (
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .rr_last (rr_last),
        .lock_en (state == ST_HOLD),
        .lock_id (grant_q),
        .sel     (sel)
    );

    assign sel_data    = (sel == REQ_OCD) ? bus.req1_data : bus.req0_data;
    assign sel_last    = (sel == REQ_OCD) ? bus.req1_last : bus.req0_last;
    assign owner_valid = (grant_q == REQ_OCD) ? bus.req1_valid : bus.req0_valid;
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign accept      = ready0 | ready1;

    // State plus datapath; sync_reset mirrors the async reset exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            data_q   <= 8'h00;
            last_q   <= 1'b0;
            grant_q  <= REQ_CPU;
            rr_last  <= REQ_OCD;
            tx_err_q <= 1'b0;
        end else if (sync_reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            data_q   <= 8'h00;
            last_q   <= 1'b0;
            grant_q  <= REQ_CPU;
            rr_last  <= REQ_OCD;
            tx_err_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                data_q  <= sel_data;
                last_q  <= sel_last;
                grant_q <= sel;
                rr_last <= sel;
            end
            case (state)
                ST_START:     cnt <= '0;
                ST_WAIT_ACT: begin
                    if (!bus.tx_active) begin
                        cnt <= cnt_inc;
                        if (cnt == ACK_LIMIT)
                            tx_err_q <= 1'b1;
                    end
                end
                ST_WAIT_DONE: cnt <= '0;
                ST_HOLD:      if (!owner_valid) cnt <= cnt_inc;
                default:      ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (accept) state_next = ST_START;
            ST_START:     state_next = ST_WAIT_ACT;
            ST_WAIT_ACT: begin
                if (bus.tx_active)
                    state_next = ST_WAIT_DONE;
                else if (cnt == ACK_LIMIT)
                    state_next = ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_active)
                    state_next = (LOCK_PACKET && !last_q) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (accept)
                    state_next = ST_START;
                else if (cnt == LOCK_LIMIT)
                    state_next = ST_IDLE;
            end
            default:      state_next = ST_IDLE;
        endcase
    end

    // Ready is held low while either reset is asserted so no byte is taken and then dropped.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        start  = (state == ST_START);
        if (!reset && !sync_reset && (state == ST_IDLE || state == ST_HOLD)) begin
            ready0 = (sel == REQ_CPU) && bus.req0_valid;
            ready1 = (sel == REQ_OCD) && bus.req1_valid;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.start_TX   = start;
    assign bus.tx_data    = data_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.tx_err     = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the bench plays both requesters and the UART_TX busy flag.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } byte_t;

    logic clk;
    logic reset;
    logic sync_reset;
    int   checks;
    int   errors;

    byte_t q0[$];
    byte_t q1[$];

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .LOCK_PACKET  (1'b1),
        .TIMEOUT_BITS (16),
        .ACK_TIMEOUT  (8),
        .LOCK_IDLE    (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the directed sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_flag(input string tag, input logic observed, input logic expected);
        checkOutput(tag, {7'd0, observed}, {7'd0, expected});
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic id, input logic [7:0] data, input logic last);
        if (id) q1.push_back({data, last});
        else    q0.push_back({data, last});
    endtask

    task automatic pop_req(input logic id);
        if (id) begin
            if (q1.size() > 0) void'(q1.pop_front());
        end else begin
            if (q0.size() > 0) void'(q0.pop_front());
        end
    endtask

    // Present each requester's queue head, or drop valid when its queue is empty.
    task automatic applyStimulus();
        if (q0.size() > 0) begin
            bus.req0_valid = 1'b1;
            bus.req0_data  = q0[0].data;
            bus.req0_last  = q0[0].last;
        end else begin
            bus.req0_valid = 1'b0;
            bus.req0_data  = 8'h00;
            bus.req0_last  = 1'b0;
        end
        if (q1.size() > 0) begin
            bus.req1_valid = 1'b1;
            bus.req1_data  = q1[0].data;
            bus.req1_last  = q1[0].last;
        end else begin
            bus.req1_valid = 1'b0;
            bus.req1_data  = 8'h00;
            bus.req1_last  = 1'b0;
        end
    endtask

    // One full transfer from the accept cycle; UART busy is raised at start and dropped two cycles later.
    task automatic serve_one(input logic exp_sel, input logic [7:0] exp_data);
        check_flag("accept_ready0", bus.req0_ready, !exp_sel);
        check_flag("accept_ready1", bus.req1_ready, exp_sel);
        cyc();
        pop_req(exp_sel);
        applyStimulus();
        bus.tx_active = 1'b1;
        #1;
        check_flag("start_pulse", bus.start_TX, 1'b1);
        checkOutput("tx_data", bus.tx_data, exp_data);
        check_flag("grant", bus.grant, exp_sel);
        check_flag("busy_start", bus.busy, 1'b1);
        check_flag("ready0_in_start", bus.req0_ready, 1'b0);
        check_flag("ready1_in_start", bus.req1_ready, 1'b0);
        cyc();
        #1;
        check_flag("start_single", bus.start_TX, 1'b0);
        check_flag("ready0_in_wait", bus.req0_ready, 1'b0);
        cyc();
        bus.tx_active = 1'b0;
        #1;
        check_flag("busy_wait_done", bus.busy, 1'b1);
        cyc();
        #1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b0;
        sync_reset     = 1'b0;
        bus.tx_active  = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h55;
        bus.req0_last  = 1'b1;
        bus.req1_valid = 1'b0;
        bus.req1_data  = 8'h00;
        bus.req1_last  = 1'b0;
        #2 reset = 1'b1;

        $display("[TB] reset state");
        cyc();
        #1;
        check_flag("rst_busy", bus.busy, 1'b0);
        check_flag("rst_start", bus.start_TX, 1'b0);
        check_flag("rst_tx_err", bus.tx_err, 1'b0);
        checkOutput("rst_tx_data", bus.tx_data, 8'h00);
        check_flag("rst_grant", bus.grant, 1'b0);
        check_flag("rst_ready0", bus.req0_ready, 1'b0);
        check_flag("rst_ready1", bus.req1_ready, 1'b0);
        reset = 1'b0;
        applyStimulus();

        $display("[TB] single byte");
        cyc();
        push_byte(1'b0, 8'h55, 1'b1);
        applyStimulus();
        #1;
        check_flag("single_busy_idle", bus.busy, 1'b0);
        serve_one(1'b0, 8'h55);
        check_flag("single_idle_after", bus.busy, 1'b0);

        $display("[TB] tie alternation");
        sync_reset = 1'b1;
        cyc();
        sync_reset = 1'b0;
        #1;
        checkOutput("sync_rst_tx_data", bus.tx_data, 8'h00);
        push_byte(1'b0, 8'hA0, 1'b1);
        push_byte(1'b0, 8'hA1, 1'b1);
        push_byte(1'b1, 8'hB0, 1'b1);
        push_byte(1'b1, 8'hB1, 1'b1);
        applyStimulus();
        #1;
        serve_one(1'b0, 8'hA0);
        serve_one(1'b1, 8'hB0);
        serve_one(1'b0, 8'hA1);
        serve_one(1'b1, 8'hB1);
        check_flag("tie_idle_after", bus.busy, 1'b0);

        $display("[TB] packet lock");
        push_byte(1'b1, 8'hC0, 1'b0);
        push_byte(1'b1, 8'hC1, 1'b0);
        push_byte(1'b1, 8'hC2, 1'b1);
        applyStimulus();
        #1;
        serve_one(1'b1, 8'hC0);
        check_flag("lock_hold_busy", bus.busy, 1'b1);
        push_byte(1'b0, 8'hD0, 1'b1);
        applyStimulus();
        #1;
        serve_one(1'b1, 8'hC1);
        serve_one(1'b1, 8'hC2);
        serve_one(1'b0, 8'hD0);

        $display("[TB] ack timeout");
        push_byte(1'b0, 8'hE0, 1'b1);
        applyStimulus();
        #1;
        check_flag("to_ready0", bus.req0_ready, 1'b1);
        cyc();
        pop_req(1'b0);
        applyStimulus();
        #1;
        check_flag("to_start", bus.start_TX, 1'b1);
        checkOutput("to_tx_data", bus.tx_data, 8'hE0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            #1;
            check_flag("to_err_early", bus.tx_err, 1'b0);
            check_flag("to_busy_wait", bus.busy, 1'b1);
        end
        cyc();
        #1;
        check_flag("to_err_set", bus.tx_err, 1'b1);
        check_flag("to_back_idle", bus.busy, 1'b0);
        push_byte(1'b0, 8'hE1, 1'b1);
        applyStimulus();
        #1;
        serve_one(1'b0, 8'hE1);
        check_flag("to_err_sticky", bus.tx_err, 1'b1);

        $display("[TB] lock release");
        push_byte(1'b1, 8'h70, 1'b0);
        applyStimulus();
        #1;
        serve_one(1'b1, 8'h70);
        push_byte(1'b0, 8'h80, 1'b1);
        applyStimulus();
        #1;
        check_flag("rel_hold_busy", bus.busy, 1'b1);
        check_flag("rel_ready0_hold", bus.req0_ready, 1'b0);
        check_flag("rel_ready1_hold", bus.req1_ready, 1'b0);
        for (int k = 2; k <= 20; k++) begin
            cyc();
            #1;
            check_flag("rel_hold_busy_k", bus.busy, 1'b1);
            check_flag("rel_ready0_k", bus.req0_ready, 1'b0);
        end
        cyc();
        #1;
        check_flag("rel_idle", bus.busy, 1'b0);
        serve_one(1'b0, 8'h80);

        $display("[TB] async reset in wait_done");
        push_byte(1'b1, 8'h91, 1'b1);
        applyStimulus();
        #1;
        check_flag("ar_ready1", bus.req1_ready, 1'b1);
        cyc();
        pop_req(1'b1);
        applyStimulus();
        bus.tx_active = 1'b1;
        #1;
        check_flag("ar_start", bus.start_TX, 1'b1);
        cyc();
        cyc();
        #1;
        check_flag("ar_busy_before", bus.busy, 1'b1);
        check_flag("ar_grant_before", bus.grant, 1'b1);
        checkOutput("ar_data_before", bus.tx_data, 8'h91);
        reset = 1'b1;
        #1;
        check_flag("ar_busy", bus.busy, 1'b0);
        checkOutput("ar_tx_data", bus.tx_data, 8'h00);
        check_flag("ar_grant", bus.grant, 1'b0);
        check_flag("ar_tx_err", bus.tx_err, 1'b0);
        check_flag("ar_start_low", bus.start_TX, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 1) bus.tx_active = 1'b0;
            #1;
            check_flag("ar_no_start", bus.start_TX, 1'b0);
            check_flag("ar_idle", bus.busy, 1'b0);
        end

        $display("[TB] sync reset in wait_done");
        push_byte(1'b1, 8'h92, 1'b1);
        applyStimulus();
        #1;
        check_flag("sr_ready1", bus.req1_ready, 1'b1);
        cyc();
        pop_req(1'b1);
        applyStimulus();
        bus.tx_active = 1'b1;
        #1;
        check_flag("sr_start", bus.start_TX, 1'b1);
        cyc();
        cyc();
        sync_reset = 1'b1;
        #1;
        check_flag("sr_busy_held", bus.busy, 1'b1);
        checkOutput("sr_data_held", bus.tx_data, 8'h92);
        check_flag("sr_grant_held", bus.grant, 1'b1);
        cyc();
        sync_reset = 1'b0;
        #1;
        check_flag("sr_busy", bus.busy, 1'b0);
        checkOutput("sr_tx_data", bus.tx_data, 8'h00);
        check_flag("sr_grant", bus.grant, 1'b0);
        bus.tx_active = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            check_flag("sr_no_start", bus.start_TX, 1'b0);
            check_flag("sr_idle", bus.busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
